reg_file_sb: RTL

//  - Parametrised register file: WIDTH-bit x 2**ADDR_W entries, two async read ports (A, B), one sync write port.
//  - Adds a per-entry scoreboard (pending bits) so the datapath controller can reserve a destination register
//    and stall dependent reads until the result is written back.
//  - Sits between the control unit and the ALU; drop-in successor of the fixed 8x16 file (defaults match it).

---
 rtl/reg_file_sb.sv | 85 ++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a per-entry pending scoreboard.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle write data and reservation state to the read ports.
module reg_file_sb #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              rsv_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic             same_addr;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             err_set;

  // A same-address write cannot clear a bit that is re-reserved on the same edge.
  always_comb begin
    same_addr = wr && rsv && (wr_addr == rsv_addr);
    cnt_inc   = rsv && !pend[rsv_addr];
    cnt_dec   = wr && pend[wr_addr] && !same_addr;
    err_set   = rsv && pend[rsv_addr] && !same_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      pend     <= '0;
      pend_cnt <= '0;
      rsv_err  <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_addr]  <= d_in;
        pend[wr_addr] <= 1'b0;
      end
      if (rsv) begin
        pend[rsv_addr] <= 1'b1;
      end
      pend_cnt <= pend_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
      if (err_set) begin
        rsv_err <= 1'b1;
      end
    end
  end

`ifdef REG_FILE_SB_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  always_comb begin
    fwd_a   = wr && !reset && (wr_addr == rd_addr_a);
    fwd_b   = wr && !reset && (wr_addr == rd_addr_b);
    d_out_a = fwd_a ? d_in : mem[rd_addr_a];
    d_out_b = fwd_b ? d_in : mem[rd_addr_b];
    busy_a  = fwd_a ? same_addr : pend[rd_addr_a];
    busy_b  = fwd_b ? same_addr : pend[rd_addr_b];
  end
`else
  always_comb begin
    d_out_a = mem[rd_addr_a];
    d_out_b = mem[rd_addr_b];
    busy_a  = pend[rd_addr_a];
    busy_b  = pend[rd_addr_b];
  end
`endif

endmodule
